// File: rtl/seq_detector_prog_pkg.sv
// seq_det_pkg: shared defaults and mode constants for the programmable sequence detector.
package seq_det_pkg;
    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W = $clog2(MAX_LEN_DEF + 1);
    localparam int CNT_W_DEF = 8;
    localparam logic OVLP = 1'b1;
    localparam logic NOOVLP = 1'b0;
    localparam logic [MAX_LEN_DEF-1:0] RST_PATTERN_DEF = 8'b10110;
    localparam int RST_LEN_DEF = 5;
endpackage

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: serial data, configuration and status bundle of the detector.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter int LW = $clog2(MAX_LEN + 1)
);
    logic x, x_valid, cfg_load, cfg_ovlp, cnt_clr;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LW-1:0] cfg_len;
    logic z, z_q, cfg_err;
    logic [CNT_W-1:0] match_cnt;
    modport master (
        output x, x_valid, cfg_load, cfg_pat, cfg_len, cfg_ovlp, cnt_clr,
        input z, z_q, match_cnt, cfg_err
    );
    modport slave (
        input x, x_valid, cfg_load, cfg_pat, cfg_len, cfg_ovlp, cnt_clr,
        output z, z_q, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detector_prog_sat_counter.sv
// sat_counter: up-counter that holds at its maximum; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else r_count <= i_clr ? '0 : (i_inc && r_count != '1) ? r_count + W'(1) : r_count;
    end
    assign o_count = r_count;
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with Mealy match,
// registered match and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
    parameter int RST_LEN = RST_LEN_DEF,
    parameter logic RST_OVLP = OVLP
) (
    input logic clk,
    input logic rst_n,
    seq_detector_prog_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic [MAX_LEN-1:0] r_pat, r_hist, w_cand, w_mask;
    logic [LW-1:0] r_len, r_fill;
    logic r_ovlp, r_err, r_zq, w_fill_ok, w_match;
    always_comb begin
        w_cand = {r_hist[MAX_LEN-2:0], bus.x};
        w_mask = (MAX_LEN'(1) << r_len) - MAX_LEN'(1);
        w_fill_ok = ((LW+1)'(r_fill) + (LW+1)'(1)) >= (LW+1)'(r_len);
        w_match = rst_n && bus.x_valid && !bus.cfg_load && !r_err && w_fill_ok
                  && ((w_cand ^ r_pat) & w_mask) == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= RST_PATTERN;
            r_len  <= LW'(RST_LEN);
            r_ovlp <= RST_OVLP;
            r_err  <= 1'b0;
            r_hist <= '0;
            r_fill <= '0;
            r_zq   <= 1'b0;
        end else begin
            r_zq <= w_match;
            if (bus.cfg_load) begin
                r_pat  <= bus.cfg_pat;
                r_len  <= bus.cfg_len;
                r_ovlp <= bus.cfg_ovlp;
                r_err  <= bus.cfg_len == '0 || bus.cfg_len > LW'(MAX_LEN);
                r_hist <= '0;
                r_fill <= '0;
            end else if (bus.x_valid) begin
                r_hist <= w_cand;
                // non-overlapping mode restarts the fill count so the next match needs len fresh bits
                r_fill <= (w_match && !r_ovlp) ? '0 : (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
            end
        end
    end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .i_inc(w_match),
        .i_clr(bus.cnt_clr),
        .o_count(bus.match_cnt)
    );
    assign bus.z = w_match;
    assign bus.z_q = r_zq;
    assign bus.cfg_err = r_err;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: scoreboard bench; a queue-based bit-history model predicts every cycle,
// a monitor compares z, z_q, counters (8-bit and 2-bit instances) and cfg_err.
module tb_seq_detector_prog;
    import seq_det_pkg::*;
    localparam int ML = 8;
    localparam int LW = $clog2(ML + 1);
    typedef struct {
        int z;
        int zq;
        int err;
        int cnt;
        int cnt2;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    seq_detector_prog_if #(.MAX_LEN(ML), .CNT_W(8)) bus ();
    seq_detector_prog_if #(.MAX_LEN(ML), .CNT_W(2)) bus2 ();
    assign bus2.x = bus.x;
    assign bus2.x_valid = bus.x_valid;
    assign bus2.cfg_load = bus.cfg_load;
    assign bus2.cfg_pat = bus.cfg_pat;
    assign bus2.cfg_len = bus.cfg_len;
    assign bus2.cfg_ovlp = bus.cfg_ovlp;
    assign bus2.cnt_clr = bus.cnt_clr;
    seq_detector_prog #(.MAX_LEN(ML), .CNT_W(8), .RST_PATTERN(8'b10110), .RST_LEN(5), .RST_OVLP(1'b1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    seq_detector_prog #(.MAX_LEN(ML), .CNT_W(2), .RST_PATTERN(8'b10110), .RST_LEN(5), .RST_OVLP(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    int vectors = 0;
    int fails = 0;
    exp_t sb[$];
    bit mq[$];
    bit [ML-1:0] m_pat;
    int m_len, m_cnt, m_cnt2;
    bit m_ovlp, m_err;
    task automatic check(input string n, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        mq.delete();
        m_pat = 8'b10110;
        m_len = 5;
        m_ovlp = OVLP;
        m_err = 0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask
    // one clock of stimulus; the model consumes it and queues the expected response
    task automatic step(input bit x, input bit v, input bit ld = 0, input bit clr = 0,
                        input bit [ML-1:0] pat = '0, input int len = 0, input bit ov = 0);
        exp_t e;
        @(negedge clk);
        bus.x = x;
        bus.x_valid = v;
        bus.cfg_load = ld;
        bus.cnt_clr = clr;
        bus.cfg_pat = pat;
        bus.cfg_len = LW'(len);
        bus.cfg_ovlp = ov;
        e.z = 0;
        if (ld) begin
            m_pat = pat;
            m_len = len;
            m_ovlp = ov;
            m_err = (len == 0 || len > ML);
            mq.delete();
        end else if (v) begin
            mq.push_back(x);
            if (mq.size() > ML) void'(mq.pop_front());
            if (!m_err && mq.size() >= m_len) begin
                e.z = 1;
                for (int i = 0; i < m_len; i++)
                    if (mq[mq.size() - m_len + i] != m_pat[m_len-1-i]) e.z = 0;
            end
            if (e.z == 1 && !m_ovlp) mq.delete();
        end
        m_cnt = clr ? 0 : (e.z == 1 && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        m_cnt2 = clr ? 0 : (e.z == 1 && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        e.zq = e.z;
        e.err = m_err;
        e.cnt = m_cnt;
        e.cnt2 = m_cnt2;
        sb.push_back(e);
    endtask
    task automatic send(input bit [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1);
        step(0, 0);
    endtask
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 0;
        bus.x = 1;
        bus.x_valid = 1;
        bus.cfg_load = 0;
        bus.cnt_clr = 0;
        model_reset();
        #2;
        check("rst_z", bus.z, 0);
        check("rst_z_q", bus.z_q, 0);
        check("rst_cnt", bus.match_cnt, 0);
        check("rst_cnt2", bus2.match_cnt, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        repeat (cycles) @(negedge clk);
        bus.x_valid = 0;
        rst_n = 1;
    endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("z", bus.z, e.z);
                @(posedge clk);
                #1;
                check("z_q", bus.z_q, e.zq);
                check("match_cnt", bus.match_cnt, e.cnt);
                check("match_cnt_w2", bus2.match_cnt, e.cnt2);
                check("cfg_err", bus.cfg_err, e.err);
            end
        end
    end
    initial begin
        bus.x = 0;
        bus.x_valid = 0;
        bus.cfg_load = 0;
        bus.cnt_clr = 0;
        bus.cfg_pat = '0;
        bus.cfg_len = '0;
        bus.cfg_ovlp = 0;
        do_reset(2);
        send(32'b10110110, 8);
        settle();
        check("t1_cnt", bus.match_cnt, 2);
        step(0, 1, 1, 1, 8'b10110, 5, NOOVLP);
        send(32'b10110110, 8);
        settle();
        check("t2_cnt", bus.match_cnt, 1);
        step(0, 0, 1, 1, 8'b10110, 5, OVLP);
        for (int i = 4; i >= 0; i--) begin
            step(1'(5'b10110 >> i), 1);
            repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 0);
        end
        settle();
        check("t3_cnt", bus.match_cnt, 1);
        step(0, 0, 1, 1, 8'hA5, 8, OVLP);
        send(32'hA5A5, 16);
        settle();
        check("t4_cnt", bus.match_cnt, 2);
        step(0, 0, 1, 0, 8'hA5, 0, OVLP);
        send(32'hA5A5A5A5, 32);
        settle();
        check("t4_err", bus.cfg_err, 1);
        step(0, 0, 1, 0, 8'h01, 9, OVLP);
        send(32'hFFFF, 16);
        do_reset(1);
        step(0, 0, 0, 1);
        send(32'b10110110110110110, 17);
        settle();
        check("t5_sat", bus2.match_cnt, 3);
        step(1, 1);
        step(1, 1);
        step(0, 1, 0, 1);
        step(0, 0);
        settle();
        check("t5_clr", bus.match_cnt, 0);
        step(0, 0, 1, 0, 8'h01, 1, OVLP);
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) step(0, 1, 1, 0, ML'($urandom), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else if (r < 12) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, r < 4,
                                  '0, 0, 0);
            else step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        step(0, 0, 1, 0, 8'b1011, 4, OVLP);
        send(32'b1011, 4);
        step(1, 1);
        step(0, 1);
        step(1, 1);
        do_reset(1);
        send(32'b0, 1);
        settle();
        check("t6_cnt", bus.match_cnt, 0);
        send(32'b10110, 5);
        settle();
        check("t6_default_cfg", bus.match_cnt, 1);
        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
